// File: rtl/mmu_pkg.sv
// mmu_pkg: shared encodings, context record and FSM states for the MMU context sequencer
package mmu_pkg;
   localparam int NUM_CTX_DEF = 4;
   localparam logic [3:0] RS_CR0 = 4'd0;
   localparam logic [3:0] RS_AR0 = 4'd1;
   localparam logic [3:0] RS_AR1 = 4'd2;
   localparam logic [3:0] RS_AR2 = 4'd3;
   localparam logic [3:0] RS_AR3 = 4'd4;
   localparam logic [2:0] FLD_LAST = 3'd4;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQBUS,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_t;
   typedef struct packed {
      logic [3:0]      mask;
      logic [3:0][6:0] page;
   } ctx_t;
   // field counter walks ar0..ar3 first so the enable mask in cr0 lands last
   function automatic logic [3:0] fld_rs(input logic [2:0] f);
      return f == 3'd0 ? RS_AR0 : f == 3'd1 ? RS_AR1 : f == 3'd2 ? RS_AR2 : f == 3'd3 ? RS_AR3 : RS_CR0;
   endfunction
   function automatic logic [7:0] fld_data(input ctx_t c, input logic [2:0] f);
      return f == FLD_LAST ? {4'b0, c.mask} : {1'b0, c.page[f[1:0]]};
   endfunction
endpackage

// File: rtl/mmu_ctx_seq_if.sv
// mmu_ctx_seq_if: config, switch handshake, CPU bus hold and MMU write-port signals
interface mmu_ctx_seq_if;
   logic       cfg_we;
   logic [1:0] cfg_ctx;
   logic [2:0] cfg_sel;
   logic [6:0] cfg_data;
   logic       sw_req;
   logic [1:0] sw_ctx;
   logic       sw_ack;
   logic       sw_done;
   logic       busy;
   logic [1:0] cur_ctx;
   logic       bus_req;
   logic       bus_grant;
   logic       mmu_en_n;
   logic       wr_n;
   logic [3:0] rs;
   logic [7:0] data_out;
   modport slave (
      input  cfg_we, cfg_ctx, cfg_sel, cfg_data, sw_req, sw_ctx, bus_grant,
      output sw_ack, sw_done, busy, cur_ctx, bus_req, mmu_en_n, wr_n, rs, data_out
   );
   modport master (
      output cfg_we, cfg_ctx, cfg_sel, cfg_data, sw_req, sw_ctx, bus_grant,
      input  sw_ack, sw_done, busy, cur_ctx, bus_req, mmu_en_n, wr_n, rs, data_out
   );
endinterface

// File: rtl/mmu_ctx_table.sv
// mmu_ctx_table: per-context mask/page storage, one field write port and one whole-context read port
module mmu_ctx_table
   import mmu_pkg::*;
#(
   parameter int NUM_CTX = NUM_CTX_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we_i,
   input  logic [1:0] waddr_i,
   input  logic [2:0] wsel_i,
   input  logic [6:0] wdata_i,
   input  logic [1:0] raddr_i,
   output ctx_t       rdata_o
);
   ctx_t tbl_q [NUM_CTX];
   // field write: sel 0 is the mask, 1..4 map to page0..3, 5..7 are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CTX; i++) tbl_q[i] <= '0;
      end else if (we_i && int'(waddr_i) < NUM_CTX) begin
         if (wsel_i == 3'd0) tbl_q[waddr_i].mask <= wdata_i[3:0];
         else if (wsel_i <= 3'd4) tbl_q[waddr_i].page[wsel_i[1:0] - 2'd1] <= wdata_i;
      end
   end
   assign rdata_o = int'(raddr_i) < NUM_CTX ? tbl_q[raddr_i] : '0;
endmodule

// File: rtl/mmu_ctx_seq.sv
// mmu_ctx_seq: holds the CPU bus and replays a snapshotted context into the MMU register port
module mmu_ctx_seq
   import mmu_pkg::*;
#(
   parameter int NUM_CTX = NUM_CTX_DEF
) (
   input logic          clk,
   input logic          reset,
   mmu_ctx_seq_if.slave io
);
   state_t     state_q;
   logic [2:0] fld_q;
   ctx_t       snap_q;
   logic [1:0] idx_q;
   logic [1:0] cur_q;
   ctx_t       rd;
   logic       accept;
   logic       active;
   mmu_ctx_table #(.NUM_CTX(NUM_CTX)) u_tbl (
      .clk    (clk),
      .reset  (reset),
      .we_i   (io.cfg_we),
      .waddr_i(io.cfg_ctx),
      .wsel_i (io.cfg_sel),
      .wdata_i(io.cfg_data),
      .raddr_i(io.sw_ctx),
      .rdata_o(rd)
   );
   assign accept = state_q == ST_IDLE && io.sw_req && !reset;
   assign active = state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_HOLD;
   // sequencer: a lost grant in any write phase falls back to REQBUS and retries the same field
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         fld_q   <= '0;
         snap_q  <= '0;
         idx_q   <= '0;
         cur_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) begin
               snap_q  <= rd;
               idx_q   <= io.sw_ctx;
               fld_q   <= '0;
               state_q <= ST_REQBUS;
            end
            ST_REQBUS: if (io.bus_grant) state_q <= ST_SETUP;
            ST_SETUP:  state_q <= io.bus_grant ? ST_STROBE : ST_REQBUS;
            ST_STROBE: state_q <= io.bus_grant ? ST_HOLD : ST_REQBUS;
            ST_HOLD: begin
               if (!io.bus_grant) state_q <= ST_REQBUS;
               else if (fld_q == FLD_LAST) state_q <= ST_DONE;
               else begin
                  fld_q   <= fld_q + 3'd1;
                  state_q <= ST_SETUP;
               end
            end
            ST_DONE: begin
               cur_q   <= idx_q;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
   assign io.sw_ack   = accept;
   assign io.sw_done  = state_q == ST_DONE;
   assign io.busy     = state_q != ST_IDLE;
   assign io.bus_req  = active || state_q == ST_REQBUS;
   assign io.cur_ctx  = cur_q;
   assign io.mmu_en_n = !(io.bus_grant && (state_q == ST_SETUP || state_q == ST_STROBE));
   assign io.wr_n     = !(io.bus_grant && state_q == ST_STROBE);
   assign io.rs       = active ? fld_rs(fld_q) : RS_CR0;
   assign io.data_out = active ? fld_data(snap_q, fld_q) : 8'd0;
endmodule
